// File: rtl/mix_pkg.sv
// Shared types and the signature step for the mixing-state frame checker.
// Imported by the interface, fold datapath and checker top.
package mix_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        COLLECT,
        FOLD,
        REPORT
    } state_t;

    function automatic word_t sig_step(
        input word_t sig,
        input word_t word
    );
        return {sig[WORD_W-2:0], sig[WORD_W-1]} ^ word;
    endfunction

endpackage

// File: rtl/mix_frame_checker_if.sv
// Word stream handshake into the frame checker.
// A word moves on a clock edge where valid and ready are both high.
interface mix_frame_checker_if;
    import mix_pkg::*;

    logic  valid;
    logic  ready;
    word_t data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );

endinterface

// File: rtl/mix_sig_fold.sv
// Iterative rotate-xor fold: one buffered word per cycle, WORDS cycles.
// The caller muxes word = buffer[k]; last flags the final fold step.
module mix_sig_fold
    import mix_pkg::*;
#(
    parameter int    WORDS = 8,
    parameter word_t SEED  = '0,
    localparam int   KW    = $clog2(WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  word_t         word,
    output logic [KW-1:0] k,
    output logic          busy,
    output logic          last,
    output word_t         sig
);

    assign last = busy && (k == KW'(WORDS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig  <= '0;
            k    <= '0;
            busy <= 1'b0;
        end else if (start) begin
            sig  <= SEED;
            k    <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            sig <= sig_step(sig, word);
            if (last) begin
                k    <= '0;
                busy <= 1'b0;
            end else begin
                k <= k + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mix_frame_checker.sv
// Self-check sink: buffers WORDS-word frames, folds them to a signature,
// compares against exp_sig and keeps saturating pass/fail counts.
module mix_frame_checker
    import mix_pkg::*;
#(
    parameter int    WORDS = 8,
    parameter word_t SEED  = 32'h0000_0000,
    parameter int    CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mix_frame_checker_if.slave   in_if,
    input  word_t                exp_sig,
    output logic                 done,
    output logic                 match,
    output word_t                sig_out,
    output logic [CNT_W-1:0]     pass_cnt,
    output logic [CNT_W-1:0]     fail_cnt
);

    localparam int KW = $clog2(WORDS);

    state_t        state;
    state_t        nxt;
    logic [KW-1:0] idx;
    word_t         mem [WORDS];

    logic          accept;
    logic          last_word;
    logic          rep;
    logic [KW-1:0] k;
    logic          busy;
    logic          fold_last;
    word_t         sig;

    assign in_if.ready = (state == COLLECT) && !busy;
    assign accept      = in_if.valid && in_if.ready;
    assign last_word   = accept && (idx == KW'(WORDS - 1));
    assign rep         = (state == REPORT);

    mix_sig_fold #(
        .WORDS (WORDS),
        .SEED  (SEED)
    ) u_fold (
        .clk   (clk),
        .rst_n (rst_n),
        .start (last_word),
        .word  (mem[k]),
        .k     (k),
        .busy  (busy),
        .last  (fold_last),
        .sig   (sig)
    );

    always_comb begin
        nxt = state;
        unique case (state)
            COLLECT: if (last_word) nxt = FOLD;
            FOLD:    if (fold_last) nxt = REPORT;
            REPORT:  nxt = COLLECT;
            default: nxt = COLLECT;
        endcase
    end

    // Buffer is never cleared: a reset just rewinds idx.
    always_ff @(posedge clk) begin
        if (accept) mem[idx] <= in_if.data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= COLLECT;
            idx      <= '0;
            done     <= 1'b0;
            match    <= 1'b0;
            sig_out  <= '0;
            pass_cnt <= '0;
            fail_cnt <= '0;
        end else begin
            state <= nxt;
            done  <= rep;
            match <= rep && (sig == exp_sig);
            if (accept) idx <= last_word ? '0 : idx + 1'b1;
            if (rep) begin
                sig_out <= sig;
                if (sig == exp_sig) begin
                    if (!(&pass_cnt)) pass_cnt <= pass_cnt + 1'b1;
                end else begin
                    if (!(&fail_cnt)) fail_cnt <= fail_cnt + 1'b1;
                end
            end
        end
    end

endmodule
